// File: rtl/hilo_muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_ctrl_if
//  Description : Decode-stage <-> HI/LO mul/div sequencer handshake bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface hilo_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             WrHi;
    logic             WrLo;
    logic [WIDTH-1:0] WrData;
    logic             RdHiLo;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             Busy;
    logic             Done;
    logic             Stall;

    // Decode side: issues ops and HI/LO accesses, observes results and stall
    modport master (
        output Start, Op, A, B, WrHi, WrLo, WrData, RdHiLo,
        input  HI, LO, Busy, Done, Stall
    );

    // Sequener side: the mul/div engine and HI/LO registers
    modport slave (
        input  Start, Op, A, B, WrHi, WrLo, WrData, RdHiLo,
        output HI, LO, Busy, Done, Stall
    );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_ctrl
//  Description : Iterative HI/LO multiply/divide sequencer. Shift-add multiply
//                and restoring divide over WIDTH cycles, sign fix-up, MTHI/
//                MTLO service and pipeline stall generation.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    hilo_muldiv_ctrl_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_a;
    logic               neg_b;
    logic               div0;
    // Multiplicand for MUL, divisor for DIV
    logic [WIDTH-1:0]   opnd;
    // MUL: {partial product}; DIV: {remainder, quotient/dividend}
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;

    logic               op_signed;
    logic               a_neg_in;
    logic               b_neg_in;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               busy;

    assign busy      = (state != IDLE);
    assign bus.Busy  = busy;
    assign bus.Done  = done;
    assign bus.HI    = hi;
    assign bus.LO    = lo;
    assign bus.Stall = busy & (bus.Start | bus.RdHiLo | bus.WrHi | bus.WrLo);

    // Operand magnitudes and sign flags at issue time
    always_comb begin
        op_signed = ~bus.Op[0];
        a_neg_in  = op_signed & bus.A[WIDTH-1];
        b_neg_in  = op_signed & bus.B[WIDTH-1];
        abs_a     = a_neg_in ? -bus.A : bus.A;
        abs_b     = b_neg_in ? -bus.B : bus.B;
    end

    // One engine iteration: shift-add multiply or restoring shift-subtract
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        // Result is below 2^WIDTH whenever it is kept, so WIDTH bits suffice
        rem_sub   = div_shift[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (div_shift >= {1'b0, opnd})
                acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction of the finished engine result
    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        // Divide by zero: quotient forced to all ones; remainder holds |A| and
        // re-applying A's sign returns A exactly as issued
        quo_fix  = div0 ? '1 :
                   ((neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Sequencer state, iteration counter and engine datapath
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            div0   <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        is_div <= bus.Op[1];
                        neg_a  <= a_neg_in;
                        neg_b  <= b_neg_in;
                        div0   <= bus.Op[1] & (bus.B == '0);
                        opnd   <= bus.Op[1] ? abs_b : abs_a;
                        acc    <= {{WIDTH{1'b0}}, (bus.Op[1] ? abs_a : abs_b)};
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // HI/LO architectural registers and the Done pulse
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                if (is_div) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end else if (state == IDLE) begin
                if (bus.WrHi)
                    hi <= bus.WrData;
                if (bus.WrLo)
                    lo <= bus.WrData;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv_ctrl
//  Description : Self-checking bench for hilo_muldiv_ctrl against a 64-bit
//                arithmetic reference of MULT/MULTU/DIV/DIVU.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    hilo_muldiv_ctrl_if #(.WIDTH(32)) bus ();

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    // Run-time guard
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference result {HI, LO} from plain arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint p, q, r;
        logic [63:0] res;
        case (op)
            2'b00: begin
                p   = longint'($signed(a)) * longint'($signed(b));
                res = p;
            end
            2'b01: res = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'h0)
                    res = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                    res = {32'h0, 32'h80000000};
                else begin
                    q   = longint'($signed(a)) / longint'($signed(b));
                    r   = longint'($signed(a)) % longint'($signed(b));
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0)
                    res = {a, 32'hFFFFFFFF};
                else
                    res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Called in the first busy cycle; follows the op to its Done cycle
    task automatic wait_done(input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input bit hazard);
        int          busy_n    = 0;
        int          stall_bad = 0;
        logic [63:0] exp       = model(op, a, b);
        while (bus.Busy && busy_n < 200) begin
            busy_n++;
            if (hazard && !bus.Stall)
                stall_bad++;
            step();
        end
        check("busy_cycles", 64'(busy_n), 64'd33);
        check("done_pulse", 64'(bus.Done), 64'd1);
        check("hi", 64'(bus.HI), {32'b0, exp[63:32]});
        check("lo", 64'(bus.LO), {32'b0, exp[31:0]});
        if (hazard) begin
            check("stall_while_busy", 64'(stall_bad), 64'd0);
            check("stall_done_cycle", 64'(bus.Stall), 64'd0);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        step();
        bus.Start = 1'b0;
        wait_done(op, a, b, 1'b0);
        step();
        check("done_once", 64'(bus.Done), 64'd0);
        check("idle_after", 64'(bus.Busy), 64'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] pool [5];
        pool[0] = 32'h0;
        pool[1] = 32'h1;
        pool[2] = 32'hFFFFFFFF;
        pool[3] = 32'h80000000;
        pool[4] = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0)
            return pool[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int done_seen;
        bus.Start  = 1'b0;
        bus.Op     = 2'b00;
        bus.A      = '0;
        bus.B      = '0;
        bus.WrHi   = 1'b0;
        bus.WrLo   = 1'b0;
        bus.WrData = '0;
        bus.RdHiLo = 1'b0;

        // Reset state
        #1;
        check("rst_hi", 64'(bus.HI), 64'd0);
        check("rst_lo", 64'(bus.LO), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_stall", 64'(bus.Stall), 64'd0);
        step();
        Rst = 1'b1;
        step();

        // MTLO / MTHI while idle
        bus.WrLo   = 1'b1;
        bus.WrData = 32'h1234;
        step();
        bus.WrLo   = 1'b0;
        check("mtlo_idle", 64'(bus.LO), 64'h1234);
        check("mtlo_hi_kept", 64'(bus.HI), 64'd0);
        bus.WrHi   = 1'b1;
        bus.WrData = 32'hDEAD0000;
        step();
        bus.WrHi   = 1'b0;
        check("mthi_idle", 64'(bus.HI), 64'hDEAD0000);

        // Reset in the middle of CALC abandons the op
        bus.Start = 1'b1;
        bus.Op    = 2'b01;
        bus.A     = 32'hFFFFFFFF;
        bus.B     = 32'hFFFFFFFF;
        step();
        bus.Start = 1'b0;
        repeat (10) step();
        #2;
        Rst = 1'b0;
        #1;
        check("midrst_hi", 64'(bus.HI), 64'd0);
        check("midrst_lo", 64'(bus.LO), 64'd0);
        check("midrst_busy", 64'(bus.Busy), 64'd0);
        check("midrst_done", 64'(bus.Done), 64'd0);
        step();
        Rst = 1'b1;
        done_seen = 0;
        repeat (40) begin
            step();
            if (bus.Done)
                done_seen++;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        check("midrst_hi_after", 64'(bus.HI), 64'd0);

        // Directed arithmetic corner cases
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(2'b00, 32'hFFFFFFFD, 32'd5);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        run_op(2'b11, 32'd100, 32'd0);
        run_op(2'b10, 32'hFFFFFF9C, 32'd0);

        // Hazard: MFHI and the next mul/div held in ID during a busy op
        bus.Start = 1'b1;
        bus.Op    = 2'b00;
        bus.A     = 32'h00012345;
        bus.B     = 32'hFFFF0003;
        step();
        bus.Op     = 2'b11;
        bus.A      = 32'hCAFEBABE;
        bus.B      = 32'h00001234;
        bus.RdHiLo = 1'b1;
        wait_done(2'b00, 32'h00012345, 32'hFFFF0003, 1'b1);
        step();
        check("b2b_started", 64'(bus.Busy), 64'd1);
        bus.Start  = 1'b0;
        bus.RdHiLo = 1'b0;
        wait_done(2'b11, 32'hCAFEBABE, 32'h00001234, 1'b0);
        step();

        // MTLO during a busy op is held off until idle
        bus.Start = 1'b1;
        bus.Op    = 2'b00;
        bus.A     = 32'hFFFFFFFD;
        bus.B     = 32'd5;
        step();
        bus.Start  = 1'b0;
        bus.WrLo   = 1'b1;
        bus.WrData = 32'h0000ABCD;
        wait_done(2'b00, 32'hFFFFFFFD, 32'd5, 1'b1);
        step();
        bus.WrLo = 1'b0;
        check("mtlo_after_busy", 64'(bus.LO), 64'h0000ABCD);
        check("mtlo_busy_hi_kept", 64'(bus.HI), 64'hFFFFFFFF);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = rnd_val();
            b  = rnd_val();
            run_op(op, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
